// File: rtl/fb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_port_arbiter: writer/reader arbiter for the single framebuffer port   |
// | with registered commands and a hold/drain quiesce FSM.                   |
// | Optional reader starvation guard: FB_ARB_STARVE_GUARD_EN                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fb_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              hold,
  output logic              idle,
  output logic [ADDR_W-1:0] fb_address,
  output logic              fb_chipselect,
  output logic              fb_clken,
  output logic              fb_write,
  output logic [DATA_W-1:0] fb_writedata,
  input  logic [DATA_W-1:0] fb_readdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
    $error("fb_port_arbiter: MAX_WAIT must be within 1..15");
  end

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rd_pipe1;
  logic   rd_pipe2;
  logic   pipe_empty;
  logic   grant_ok;
  logic   force_rd;
  logic   wr_go;
  logic   rd_go;

  // hold gates grants already in RUN so no new read slips in behind a drain request
  assign grant_ok = (state == RUN) && !hold;
  assign wr_ready = grant_ok && wr_req && !force_rd;
  assign rd_ready = grant_ok && rd_req && (!wr_req || force_rd);
  assign wr_go    = wr_req && wr_ready;
  assign rd_go    = rd_req && rd_ready;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
  logic [3:0] starve_cnt;

  // Saturates at MAX_CNT so a hold during a forced cycle cannot wrap the count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      starve_cnt <= 4'd0;
    end else if (!rd_req || rd_go) begin
      starve_cnt <= 4'd0;
    end else if (state == RUN && starve_cnt != MAX_CNT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_rd = (starve_cnt == MAX_CNT);
`else
  assign force_rd = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fb_address    <= '0;
      fb_writedata  <= '0;
      fb_chipselect <= 1'b0;
      fb_clken      <= 1'b0;
      fb_write      <= 1'b0;
      rd_pipe1      <= 1'b0;
      rd_pipe2      <= 1'b0;
    end else begin
      fb_chipselect <= wr_go || rd_go;
      fb_clken      <= wr_go || rd_go;
      fb_write      <= wr_go;
      if (wr_go) begin
        fb_address   <= wr_addr;
        fb_writedata <= wr_data;
      end else if (rd_go) begin
        fb_address   <= rd_addr;
      end
      rd_pipe1 <= rd_go;
      rd_pipe2 <= rd_pipe1;
    end
  end

  assign pipe_empty = !rd_pipe1 && !rd_pipe2;
  assign rd_valid   = rd_pipe2;
  assign rd_data    = fb_readdata;
  assign idle       = (state == HALTED);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (hold) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty)  state_nxt = HALTED;
        else if (!hold)  state_nxt = RUN;
      end
      HALTED: begin
        if (!hold) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_port_arbiter: randomized and directed bench for fb_port_arbiter    |
// | against a transaction-level reference model.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fb_port_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 4;
`ifdef FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              hold = 1'b0;
  logic              idle;
  logic [ADDR_W-1:0] fb_address;
  logic              fb_chipselect;
  logic              fb_clken;
  logic              fb_write;
  logic [DATA_W-1:0] fb_writedata;
  logic [DATA_W-1:0] fb_readdata = '0;

  fb_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .hold          (hold),
    .idle          (idle),
    .fb_address    (fb_address),
    .fb_chipselect (fb_chipselect),
    .fb_clken      (fb_clken),
    .fb_write      (fb_write),
    .fb_writedata  (fb_writedata),
    .fb_readdata   (fb_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  // Framebuffer memory with 1-cycle read latency.
  logic [DATA_W-1:0] fbmem [logic [ADDR_W-1:0]];
  always @(posedge clk_clk) begin
    if (fb_chipselect) begin
      if (fb_write) fbmem[fb_address] = fb_writedata;
      else fb_readdata <= fbmem.exists(fb_address) ? fbmem[fb_address] : '0;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model: port mode, starvation count, expected command and read returns.
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  rd_t               rdq[$];
  logic [DATA_W-1:0] refmem [logic [ADDR_W-1:0]];
  int                m_state, m_cnt, cyc;
  logic              e_cs, e_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wd;
  logic              obs_wr, obs_rd;

  function automatic logic [DATA_W-1:0] rm(input logic [ADDR_W-1:0] a);
    return refmem.exists(a) ? refmem[a] : '0;
  endfunction

  task automatic model_reset();
    rdq.delete();
    m_state = M_RUN;
    m_cnt   = 0;
    e_cs    = 1'b0;
    e_wr    = 1'b0;
    e_addr  = '0;
    e_wd    = '0;
  endtask

  task automatic step(input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic r, input logic [ADDR_W-1:0] ra, input logic h);
    logic frc, ok, ewr, erd, exp_v, empty;
    @(negedge clk_clk);
    wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = r; rd_addr = ra; hold = h;
    #1;
    frc = GUARD && (m_cnt == MAX_WAIT);
    ok  = (m_state == M_RUN) && !h;
    ewr = ok && w && !frc;
    erd = ok && r && (!w || frc);
    obs_wr = wr_ready;
    obs_rd = rd_ready;
    check_eq("wr_ready", wr_ready, ewr);
    check_eq("rd_ready", rd_ready, erd);
    check_eq("idle", idle, m_state == M_HALT);
    check_eq("fb_chipselect", fb_chipselect, e_cs);
    check_eq("fb_clken", fb_clken, e_cs);
    check_eq("fb_write", fb_write, e_wr);
    check_eq("fb_address", fb_address, e_addr);
    check_eq("fb_writedata", fb_writedata, e_wd);
    empty = (rdq.size() == 0);
    exp_v = !empty && rdq[0].due == cyc;
    check_eq("rd_valid", rd_valid, exp_v);
    if (exp_v) begin
      check_eq("rd_data", rd_data, rdq[0].data);
      void'(rdq.pop_front());
    end
    if (!r || erd) m_cnt = 0;
    else if (m_state == M_RUN && m_cnt < MAX_WAIT) m_cnt++;
    e_cs = ewr || erd;
    e_wr = ewr;
    if (ewr) begin
      e_addr = wa;
      e_wd   = wd;
      refmem[wa] = wd;
    end else if (erd) begin
      e_addr = ra;
      rdq.push_back('{due: cyc + 2, data: rm(ra)});
    end
    case (m_state)
      M_RUN:   if (h) m_state = M_DRAIN;
      M_DRAIN: if (empty) m_state = M_HALT; else if (!h) m_state = M_RUN;
      default: if (!h) m_state = M_RUN;
    endcase
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rd_valid"}, rd_valid, 1'b0);
    check_eq({pfx, "_idle"}, idle, 1'b0);
    check_eq({pfx, "_cs"}, fb_chipselect, 1'b0);
    check_eq({pfx, "_clken"}, fb_clken, 1'b0);
    check_eq({pfx, "_write"}, fb_write, 1'b0);
    check_eq({pfx, "_addr"}, fb_address, '0);
    check_eq({pfx, "_wdata"}, fb_writedata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_grants, wr_grants;
    logic hh;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk_clk);
    #1 check_reset_outputs("reset");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Single write then read-back.
    step(1'b1, 19'h00010, 8'hA5, 1'b0, '0, 1'b0);
    check_eq("wr_handshake", obs_wr, 1'b1);
    idle_step();
    step(1'b0, '0, '0, 1'b1, 19'h00010, 1'b0);
    repeat (4) idle_step();

    // Sustained contention.
    rd_grants = 0;
    wr_grants = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 19'(i), 8'(i * 7), 1'b1, 19'(i + 3), 1'b0);
      rd_grants += int'(obs_rd);
      wr_grants += int'(obs_wr);
    end
    check_eq("contend_rd_grants", rd_grants, GUARD ? 4 : 0);
    check_eq("contend_wr_grants", wr_grants, GUARD ? 16 : 20);
    repeat (3) idle_step();

    // Hold with a read in flight.
    step(1'b0, '0, '0, 1'b1, 19'h00003, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 19'h00020, 8'h11, 1'b1, 19'h00021, 1'b1);
      check_eq("hold_no_ready", {obs_wr, obs_rd}, 2'b00);
    end
    check_eq("idle_by_t4", idle, 1'b1);
    idle_step();
    step(1'b1, 19'h00022, 8'h5A, 1'b0, '0, 1'b0);
    check_eq("resume_wr", obs_wr, 1'b1);
    repeat (2) idle_step();

    // Back-to-back reads at the address extremes.
    step(1'b0, '0, '0, 1'b1, 19'h7FFFF, 1'b0);
    step(1'b0, '0, '0, 1'b1, 19'h00000, 1'b0);
    repeat (4) idle_step();

    // Reset while a read is in flight.
    step(1'b0, '0, '0, 1'b1, 19'h00010, 1'b0);
    @(posedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    wr_req = 1'b0; rd_req = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (4) idle_step();

    // Randomized traffic with occasional hold bursts.
    hh = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) hh = ~hh;
      step(1'($urandom_range(1)), 19'($urandom_range(15)), 8'($urandom),
           1'($urandom_range(1)), 19'($urandom_range(15)), hh);
    end
    repeat (6) idle_step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
